// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
// Pipeline register between the execute stage and the memory stage. It is
// a 2-entry skid buffer: the main entry drives the outputs and the skid
// entry catches one more instruction while the memory stage is stalled.
// in_ready depends only on the registered state, so there is no
// combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous kill of all held entries and of the input
//   in_valid/ready  execute-side handshake
//   in_data/addr/pc/jmp (DW), in_wreg (RW), in_ctrl (6) execute results
//   out_valid/ready memory-side handshake
//   out_data/addr/pc/jmp/wreg  registered copies of the main entry
//   out_ctrl        main entry control, forced to zero while out_valid=0
//   occupancy       number of entries held (0..2)
module ex_mem_pipe #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] in_addr,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_jmp,
  input  logic [RW-1:0] in_wreg,
  input  logic [5:0]    in_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] out_addr,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_jmp,
  output logic [RW-1:0] out_wreg,
  output logic [5:0]    out_ctrl,
  output logic [1:0]    occupancy
);

  // ctrl bit order: {wb, memwrt, brchcnd, alujmp, setrd, regsrc}
  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] addr;
    logic [DW-1:0] pc;
    logic [DW-1:0] jmp;
    logic [RW-1:0] wreg;
    logic [5:0]    ctrl;
  } entry_t;

  // The state encoding is the occupancy count itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   fire;

  assign in_entry = '{data: in_data, addr: in_addr, pc: in_pc, jmp: in_jmp,
                      wreg: in_wreg, ctrl: in_ctrl};

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;

  // Flush must block capture even though in_ready may still read 1.
  assign accept = in_valid & in_ready & ~flush;
  assign fire   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Stored fields are left alone; they are don't-care once invalid.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain case exists.
          if (fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_data = main_q.data;
  assign out_addr = main_q.addr;
  assign out_pc   = main_q.pc;
  assign out_jmp  = main_q.jmp;
  assign out_wreg = main_q.wreg;
  // Bubbles carry zero control so memory never sees a stray write.
  assign out_ctrl = main_q.ctrl & {6{out_valid}};

endmodule
